// File: rtl/afifo_chk_pkg.sv
// Shared definitions for the async-FIFO sequence checker and its pacing helper.
package afifo_chk_pkg;

    localparam logic [1:0] SEED  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] LOST  = 2'd2;

    // Holds at all-ones of the given width instead of wrapping (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val == max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/afifo_pace_gen.sv
// Free-running modulo-PACE_N phase counter; pace_ok marks the one permitted cycle per period.
module afifo_pace_gen #(
    parameter int PACE_N = 1
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic clr,
    output logic pace_ok
);

    localparam int PW = (PACE_N > 1) ? $clog2(PACE_N) : 1;

    logic [PW-1:0] r_cnt;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt == PW'(PACE_N - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    assign pace_ok = (r_cnt == '0);

endmodule

// File: rtl/afifo_seq_checker.sv
// Fall-through FIFO consumer that pops at a paced rate and checks for an incrementing byte sequence.
//   state | meaning
//   SEED  | waiting for the first byte to seed the expected value
//   TRACK | locked, comparing each popped byte against expected
//   LOST  | too many consecutive mismatches, next byte reseeds
module afifo_seq_checker
    import afifo_chk_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter int CNT_W       = 16,
    parameter int PACE_N      = 1,
    parameter int LOST_THRESH = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             clr,
    output logic             locked,
    output logic             err_sticky,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [DSIZE-1:0] first_exp,
    output logic [DSIZE-1:0] first_got,
    output logic             stalled
);

    localparam int CW = (LOST_THRESH > 1) ? $clog2(LOST_THRESH) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    logic             w_pace_ok;
    logic             w_pop;
    logic             w_match;
    logic             w_lose;
    logic             w_in_track;
    logic             w_cnt_good;
    logic             w_cnt_err;
    logic [1:0]       w_state_nxt;
    logic [IW-1:0]    w_idle_nxt;

    logic [1:0]       r_state;
    logic [DSIZE-1:0] r_expected;
    logic [CW-1:0]    r_consec;
    logic [IW-1:0]    r_idle;
    logic             r_stalled;
    logic             r_sticky;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_err;
    logic [DSIZE-1:0] r_first_exp;
    logic [DSIZE-1:0] r_first_got;

    afifo_pace_gen #(
        .PACE_N (PACE_N)
    ) u_pace (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .clr     (clr),
        .pace_ok (w_pace_ok)
    );

    assign w_pop   = !rempty && w_pace_ok && !clr;
    assign rinc    = w_pop;
    assign w_match = (rdata == r_expected);
    // The count is bumped on this mismatch, so threshold-1 stored means threshold reached.
    assign w_lose  = (r_consec == CW'(LOST_THRESH - 1)) || (LOST_THRESH <= 1);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= SEED;
        end else if (clr) begin
            r_state <= SEED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEED, LOST: if (w_pop) w_state_nxt = TRACK;
            TRACK:      if (w_pop && !w_match && w_lose) w_state_nxt = LOST;
            default:    w_state_nxt = SEED;
        endcase
    end

    always_comb begin
        w_in_track = (r_state == TRACK);
        w_cnt_good = w_pop && w_in_track && w_match;
        w_cnt_err  = w_pop && w_in_track && !w_match;
        w_idle_nxt = r_idle;
        if (w_pop || !w_in_track) begin
            w_idle_nxt = '0;
        end else if (r_idle != IW'(TIMEOUT)) begin
            w_idle_nxt = r_idle + IW'(1);
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_expected  <= '0;
            r_consec    <= '0;
            r_idle      <= '0;
            r_stalled   <= 1'b0;
            r_sticky    <= 1'b0;
            r_good      <= '0;
            r_err       <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (clr) begin
            r_expected  <= '0;
            r_consec    <= '0;
            r_idle      <= '0;
            r_stalled   <= 1'b0;
            r_sticky    <= 1'b0;
            r_good      <= '0;
            r_err       <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_idle    <= w_idle_nxt;
            r_stalled <= (w_idle_nxt == IW'(TIMEOUT));
            // Seed, match and realign all land on rdata+1.
            if (w_pop) begin
                r_expected <= rdata + DSIZE'(1);
            end
            if (w_pop && !w_in_track) begin
                r_consec <= '0;
            end
            if (w_cnt_good) begin
                r_good   <= CNT_W'(sat_inc(32'(r_good), CNT_W));
                r_consec <= '0;
            end
            if (w_cnt_err) begin
                r_err    <= CNT_W'(sat_inc(32'(r_err), CNT_W));
                r_sticky <= 1'b1;
                r_consec <= w_lose ? '0 : r_consec + CW'(1);
                if (!r_sticky) begin
                    r_first_exp <= r_expected;
                    r_first_got <= rdata;
                end
            end
        end
    end

    assign locked     = (r_state == TRACK);
    assign err_sticky = r_sticky;
    assign good_cnt   = r_good;
    assign err_cnt    = r_err;
    assign first_exp  = r_first_exp;
    assign first_got  = r_first_got;
    assign stalled    = r_stalled;

endmodule
